// File: rtl/tap_window_3.sv
// Streaming 3-tap window former feeding a 3-input signed adder.
// Presents the newest three samples of a line as (m_a newest, m_b, m_c oldest); windows never cross s_last.
module tap_window_3 #(
  parameter int unsigned DATA_W = 29
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] m_a,
  output logic signed [DATA_W-1:0] m_b,
  output logic signed [DATA_W-1:0] m_c,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     err_short
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    PRIMED = 2'd2
  } fill_e;

  fill_e                     r_fill;
  fill_e                     w_fill_nxt;
  logic signed [DATA_W-1:0]  r_h0;
  logic signed [DATA_W-1:0]  r_h1;
  logic signed [DATA_W-1:0]  r_m_a;
  logic signed [DATA_W-1:0]  r_m_b;
  logic signed [DATA_W-1:0]  r_m_c;
  logic                      r_m_last;
  logic                      r_m_valid;
  logic                      r_err_short;
  logic                      w_in_acc;
  logic                      w_shift;
  logic                      w_load;
  logic                      w_err;

  // Output register is the only buffer: accept whenever it is empty or draining.
  assign s_ready   = !r_m_valid | m_ready;
  assign w_in_acc  = s_valid & s_ready;

  assign m_a       = r_m_a;
  assign m_b       = r_m_b;
  assign m_c       = r_m_c;
  assign m_last    = r_m_last;
  assign m_valid   = r_m_valid;
  assign err_short = r_err_short;

  // Fill-level state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= EMPTY;
    end else begin
      r_fill <= w_fill_nxt;
    end
  end

  // Next fill level and datapath strobes; s_last always restarts the line.
  always_comb begin
    w_fill_nxt = r_fill;
    w_shift    = 1'b0;
    w_load     = 1'b0;
    w_err      = 1'b0;
    if (w_in_acc) begin
      w_shift = 1'b1;
      case (r_fill)
        EMPTY:   w_fill_nxt = ONE;
        ONE:     w_fill_nxt = PRIMED;
        PRIMED:  w_load     = 1'b1;
        default: w_fill_nxt = EMPTY;
      endcase
      if (s_last) begin
        w_fill_nxt = EMPTY;
        w_err      = (r_fill != PRIMED);
      end
    end
  end

  // History shift and output window register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h0        <= '0;
      r_h1        <= '0;
      r_m_a       <= '0;
      r_m_b       <= '0;
      r_m_c       <= '0;
      r_m_last    <= 1'b0;
      r_m_valid   <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      if (w_shift) begin
        r_h1 <= r_h0;
        r_h0 <= s_data;
      end
      if (w_load) begin
        r_m_a    <= s_data;
        r_m_b    <= r_h0;
        r_m_c    <= r_h1;
        r_m_last <= s_last;
      end
      r_m_valid   <= w_load | (r_m_valid & !m_ready);
      r_err_short <= w_err;
    end
  end

endmodule

// File: tb/tb_tap_window_3.sv
// Bench for tap_window_3: line-level queue model checked every cycle, plus literal window checks per scenario.
module tb_tap_window_3;
  localparam int unsigned DW = 29;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] s_data;
  logic                 s_last;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] m_a;
  logic signed [DW-1:0] m_b;
  logic signed [DW-1:0] m_c;
  logic                 m_last;
  logic                 m_valid;
  logic                 m_ready;
  logic                 err_short;

  tap_window_3 #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready), .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .err_short(err_short)
  );

  typedef struct {
    int a;
    int b;
    int c;
    bit l;
  } win_t;

  int   total = 0;
  int   bad   = 0;
  win_t exp_q[$];
  int   line_q[$];
  bit   err_exp = 0;
  bit   started = 0;
  win_t log_q[$];
  int   err_cnt = 0;
  int   stall_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_win(string tag, int idx, int a, int b, int c, bit l);
    if (idx >= log_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s missing window %0d actual_count=%0d", tag, idx, log_q.size());
    end else begin
      chk({tag, "_a"}, log_q[idx].a, a);
      chk({tag, "_b"}, log_q[idx].b, b);
      chk({tag, "_c"}, log_q[idx].c, c);
      chk({tag, "_last"}, longint'(log_q[idx].l), longint'(l));
      chk({tag, "_sum"}, longint'(log_q[idx].a) + log_q[idx].b + log_q[idx].c,
          longint'(a) + b + c);
    end
  endfunction

  // Model + per-cycle compare: compare at negedge, advance model at posedge using negedge samples.
  initial begin
    bit   v_rst, v_in, v_out, v_l;
    int   v_d;
    win_t w;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_valid", longint'(m_valid), longint'(exp_q.size() != 0));
        chk("s_ready", longint'(s_ready), longint'((exp_q.size() == 0) || m_ready));
        chk("err_short", longint'(err_short), longint'(err_exp));
        if (exp_q.size() != 0 && m_valid) begin
          chk("m_a", longint'(m_a), exp_q[0].a);
          chk("m_b", longint'(m_b), exp_q[0].b);
          chk("m_c", longint'(m_c), exp_q[0].c);
          chk("m_last", longint'(m_last), longint'(exp_q[0].l));
        end
        if (m_valid && m_ready) begin
          w.a = int'(m_a); w.b = int'(m_b); w.c = int'(m_c); w.l = m_last;
          log_q.push_back(w);
        end
        if (m_valid && !m_ready) stall_cnt++;
        if (err_short) err_cnt++;
      end
      v_rst = rst;
      v_in  = s_valid && s_ready;
      v_out = m_valid && m_ready;
      v_d   = int'(s_data);
      v_l   = s_last;
      @(posedge clk);
      if (v_rst) begin
        exp_q.delete();
        line_q.delete();
        err_exp = 0;
        started = 1;
      end else begin
        err_exp = 0;
        if (v_out && exp_q.size() != 0) void'(exp_q.pop_front());
        if (v_in) begin
          line_q.push_back(v_d);
          if (line_q.size() >= 3) begin
            w.a = v_d;
            w.b = line_q[line_q.size()-2];
            w.c = line_q[line_q.size()-3];
            w.l = v_l;
            exp_q.push_back(w);
          end
          if (v_l) begin
            if (line_q.size() < 3) err_exp = 1;
            line_q.delete();
          end
        end
      end
    end
  end

  task automatic send(input int d, input bit l);
    bit ok = 0;
    s_data  = DW'(d);
    s_last  = l;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%0d actual=stalled required=accepted", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_a", longint'(m_a), 0);
    chk("rst_m_b", longint'(m_b), 0);
    chk("rst_m_c", longint'(m_c), 0);
    chk("rst_m_last", longint'(m_last), 0);
    chk("rst_s_ready", longint'(s_ready), 1);
    idle(1);

    // 1: basic line
    log_q.delete();
    send(5, 0); send(-3, 0); send(7, 0); send(2, 1);
    idle(4);
    chk("t1_nwin", log_q.size(), 2);
    chk_win("t1_w0", 0, 7, -3, 5, 0);
    chk_win("t1_w1", 1, 2, 7, -3, 1);
    chk("t1_sum0", longint'(log_q.size() > 0 ? log_q[0].a + log_q[0].b + log_q[0].c : 0), 9);

    // 2: short line then normal line
    log_q.delete(); err_cnt = 0;
    send(1, 0); send(2, 1);
    idle(3);
    chk("t2_err_pulses", err_cnt, 1);
    chk("t2_nwin_short", log_q.size(), 0);
    send(4, 0); send(5, 0); send(6, 1);
    idle(4);
    chk("t2_nwin", log_q.size(), 1);
    chk_win("t2_w0", 0, 6, 5, 4, 1);

    // 3: back-to-back lines
    log_q.delete(); err_cnt = 0;
    send(1, 0); send(2, 0); send(3, 1);
    send(10, 0); send(20, 0); send(30, 1);
    idle(4);
    chk("t3_nwin", log_q.size(), 2);
    chk_win("t3_w0", 0, 3, 2, 1, 1);
    chk_win("t3_w1", 1, 30, 20, 10, 1);
    chk("t3_err", err_cnt, 0);

    // 4: downstream stall
    log_q.delete(); stall_cnt = 0;
    m_ready = 1'b0;
    send(1, 0); send(2, 0); send(3, 0);
    fork
      begin send(4, 0); send(5, 1); end
      begin idle(6); m_ready = 1'b1; end
    join
    idle(4);
    chk("t4_stall_ge4", longint'(stall_cnt >= 4), 1);
    chk("t4_nwin", log_q.size(), 3);
    chk_win("t4_w0", 0, 3, 2, 1, 0);
    chk_win("t4_w1", 1, 4, 3, 2, 0);
    chk_win("t4_w2", 2, 5, 4, 3, 1);

    // 5: extreme negative samples
    log_q.delete();
    send(-268435456, 0); send(-268435456, 0); send(-268435456, 1);
    idle(4);
    chk("t5_nwin", log_q.size(), 1);
    chk_win("t5_w0", 0, -268435456, -268435456, -268435456, 1);
    chk("t5_sum", longint'(log_q.size() > 0 ? longint'(log_q[0].a) + log_q[0].b + log_q[0].c : 0),
        -805306368);

    // 6: reset mid-line
    log_q.delete();
    send(1, 0); send(2, 0);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("t6_rst_m_valid", longint'(m_valid), 0);
    idle(1);
    rst = 1'b0;
    send(7, 0); send(8, 0); send(9, 1);
    idle(4);
    chk("t6_nwin", log_q.size(), 1);
    chk_win("t6_w0", 0, 9, 8, 7, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
